// File: rtl/peripheral_spram_arbiter.sv
// Purpose : round-robin arbiter with optional lock, sharing one single-port SPRAM between two masters.
// Latency : grant and RAM strobe in the request cycle; ack, err and read data one cycle later.
// Backpres: a master that is not granted must hold req until gnt; both masters requesting get alternate slots.
//
// Ports:
//   ram_clk / ram_rst_n        : clock shared with the RAM, async active-low reset
//   mX_req/lock/addr/wen/din   : master X request, burst lock, word address, low-active byte writes, write data
//   mX_gnt                     : combinational grant for the current cycle
//   mX_ack/err/dout            : registered completion, out-of-range flag and read data for the last grant
//   ram_addr/cen/wen/din/dout  : direct connection to the SPRAM port
module peripheral_spram_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MEM_SIZE = 256
) (
  input  logic          ram_clk,
  input  logic          ram_rst_n,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [1:0]    m0_wen,
  input  logic [DW-1:0] m0_din,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_dout,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [1:0]    m1_wen,
  input  logic [DW-1:0] m1_din,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_dout,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cen,
  output logic [1:0]    ram_wen,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE / 2);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  owner_e owner_q, owner_d;
  logic   last_q, last_d;       // 1: master 1 won the most recent grant
  logic   [1:0] ack_q, ack_d;   // one-hot: which master gets the ack this cycle
  logic   err_q, err_d;
  logic   rd_q, rd_d;           // completed access was an in-range read

  logic          gnt0, gnt1, any_gnt, in_range;
  logic [AW-1:0] sel_addr;
  logic [1:0]    sel_wen;
  logic [DW-1:0] sel_din;

  // Arbitration. Grants are suppressed while reset is held so the RAM is
  // never strobed during reset. A lock only holds ownership while the owner
  // keeps both req and lock high; otherwise that cycle arbitrates normally.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ram_rst_n) begin
      if (owner_q == OWN_M0 && m0_req && m0_lock) begin
        gnt0 = 1'b1;
      end else if (owner_q == OWN_M1 && m1_req && m1_lock) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req && !m0_req;
      end
    end
  end

  always_comb begin
    any_gnt  = gnt0 | gnt1;
    sel_addr = gnt1 ? m1_addr : m0_addr;
    sel_wen  = gnt1 ? m1_wen  : m0_wen;
    sel_din  = gnt1 ? m1_din  : m0_din;
    in_range = 32'(sel_addr) < MEM_WORDS;
  end

  // An out-of-range grant still uses the slot but keeps the RAM deselected.
  always_comb begin
    ram_cen  = !(any_gnt && in_range);
    ram_wen  = any_gnt ? sel_wen  : 2'b11;
    ram_addr = any_gnt ? sel_addr : '0;
    ram_din  = any_gnt ? sel_din  : '0;
  end

  always_comb begin
    ack_d  = {gnt1, gnt0};
    err_d  = any_gnt && !in_range;
    rd_d   = any_gnt && in_range && (sel_wen == 2'b11);
    last_d = any_gnt ? gnt1 : last_q;
    if (gnt0 && m0_lock) begin
      owner_d = OWN_M0;
    end else if (gnt1 && m1_lock) begin
      owner_d = OWN_M1;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // The RAM presents read data in the cycle after the grant, so the return
  // path is a gate on ram_dout rather than another register stage.
  always_comb begin
    m0_gnt  = gnt0;
    m1_gnt  = gnt1;
    m0_ack  = ack_q[0];
    m1_ack  = ack_q[1];
    m0_err  = ack_q[0] && err_q;
    m1_err  = ack_q[1] && err_q;
    m0_dout = (ack_q[0] && rd_q) ? ram_dout : '0;
    m1_dout = (ack_q[1] && rd_q) ? ram_dout : '0;
  end

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
module tb_peripheral_spram_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int WORDS = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 0, m0_lock = 0, m1_req = 0, m1_lock = 0;
  logic [AW-1:0] m0_addr = 0, m1_addr = 0;
  logic [1:0]    m0_wen = 2'b11, m1_wen = 2'b11;
  logic [DW-1:0] m0_din = 0, m1_din = 0;
  logic          m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
  logic [DW-1:0] m0_dout, m1_dout;
  logic [AW-1:0] ram_addr;
  logic          ram_cen;
  logic [1:0]    ram_wen;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_spram_arbiter #(.AW(AW), .DW(DW), .MEM_SIZE(256)) dut (
    .ram_clk(clk), .ram_rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_dout(m1_dout),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // SPRAM: registered address, data out the cycle after the strobe.
  logic [DW-1:0] ram_mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) ram_mem[i] = '0;

  always @(posedge clk) begin
    if (!ram_cen) begin
      if (ram_wen == 2'b11) begin
        ram_dout <= ram_mem[ram_addr[6:0]];
      end else begin
        if (!ram_wen[1]) ram_mem[ram_addr[6:0]][15:8] <= ram_din[15:8];
        if (!ram_wen[0]) ram_mem[ram_addr[6:0]][7:0]  <= ram_din[7:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the RAM, who won last, and what each master
  // must see next cycle.
  logic [DW-1:0] mmem [WORDS];
  initial for (int i = 0; i < WORDS; i++) mmem[i] = '0;
  int            own  = -1;
  int            last = 1;
  int            win;
  logic          pend_ack [2];
  logic          pend_err [2];
  logic [DW-1:0] pend_dout [2];
  logic          rq [2];
  logic          lk [2];
  logic [AW-1:0] ad [2];
  logic [1:0]    we [2];
  logic [DW-1:0] dn [2];
  logic          inr;
  initial begin
    pend_ack  = '{1'b0, 1'b0};
    pend_err  = '{1'b0, 1'b0};
    pend_dout = '{16'h0, 16'h0};
  end

  always @(negedge clk) begin
    rq = '{m0_req, m1_req};
    lk = '{m0_lock, m1_lock};
    ad = '{m0_addr, m1_addr};
    we = '{m0_wen, m1_wen};
    dn = '{m0_din, m1_din};
    if (!rst_n) begin
      own = -1;
      last = 1;
      pend_ack  = '{1'b0, 1'b0};
      pend_err  = '{1'b0, 1'b0};
      pend_dout = '{16'h0, 16'h0};
      chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
      chk("rst_ack", {m1_ack, m0_ack, m1_err, m0_err}, 0);
      chk("rst_dout", {m1_dout, m0_dout}, 0);
      chk("rst_ram", {ram_cen, ram_wen, ram_addr, ram_din}, {1'b1, 2'b11, 8'h0, 16'h0});
    end else begin
      chk("m0_ack", m0_ack, pend_ack[0]);
      chk("m1_ack", m1_ack, pend_ack[1]);
      chk("m0_err", m0_err, pend_err[0]);
      chk("m1_err", m1_err, pend_err[1]);
      chk("m0_dout", m0_dout, pend_dout[0]);
      chk("m1_dout", m1_dout, pend_dout[1]);

      win = -1;
      if (own >= 0 && rq[own] && lk[own]) win = own;
      else if (rq[0] && rq[1])            win = 1 - last;
      else if (rq[0])                     win = 0;
      else if (rq[1])                     win = 1;

      chk("m0_gnt", m0_gnt, win == 0);
      chk("m1_gnt", m1_gnt, win == 1);

      pend_ack  = '{1'b0, 1'b0};
      pend_err  = '{1'b0, 1'b0};
      pend_dout = '{16'h0, 16'h0};
      if (win < 0) begin
        chk("idle_ram", {ram_cen, ram_wen, ram_addr, ram_din}, {1'b1, 2'b11, 8'h0, 16'h0});
        own = -1;
      end else begin
        inr = ad[win] < WORDS;
        chk("ram_cen", ram_cen, !inr);
        chk("ram_port", {ram_wen, ram_addr, ram_din}, {we[win], ad[win], dn[win]});
        pend_ack[win] = 1'b1;
        pend_err[win] = !inr;
        if (inr && we[win] == 2'b11) pend_dout[win] = mmem[ad[win][6:0]];
        if (inr && !we[win][1]) mmem[ad[win][6:0]][15:8] = dn[win][15:8];
        if (inr && !we[win][0]) mmem[ad[win][6:0]][7:0]  = dn[win][7:0];
        last = win;
        own  = lk[win] ? win : -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, input logic l, input logic [AW-1:0] a,
                      input logic [1:0] w, input logic [DW-1:0] d);
    m0_req = r; m0_lock = l; m0_addr = a; m0_wen = w; m0_din = d;
  endtask

  task automatic drv1(input logic r, input logic l, input logic [AW-1:0] a,
                      input logic [1:0] w, input logic [DW-1:0] d);
    m1_req = r; m1_lock = l; m1_addr = a; m1_wen = w; m1_din = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    #2 chk("idle_cen", ram_cen, 1'b1);

    // Full-word write then read of the same word.
    tick(); drv0(1, 0, 8'd5, 2'b00, 16'hA55A);
    #2 chk("wr_gnt", m0_gnt, 1'b1);
    chk("wr_cen", ram_cen, 1'b0);
    tick(); drv0(1, 0, 8'd5, 2'b11, 16'h0);
    #2 chk("wr_ack", m0_ack, 1'b1);
    chk("wr_dout", m0_dout, 16'h0);
    tick(); drv0(0, 0, 8'd0, 2'b11, 16'h0);
    #2 chk("rd_ack", m0_ack, 1'b1);
    chk("rd_dout", m0_dout, 16'hA55A);

    // Both masters streaming reads: M0 won last, so M1 takes the first tie.
    tick(); drv0(1, 0, 8'd1, 2'b11, 16'h0); drv1(1, 0, 8'd2, 2'b11, 16'h0);
    #2 chk("rr_first_m1", {m1_gnt, m0_gnt}, 2'b10);
    tick();
    #2 chk("rr_second_m0", {m1_gnt, m0_gnt}, 2'b01);
    repeat (6) tick();
    drv0(0, 0, 8'd0, 2'b11, 16'h0); drv1(0, 0, 8'd0, 2'b11, 16'h0);

    // Locked burst from M1 while M0 keeps requesting.
    tick(); drv0(1, 0, 8'd3, 2'b11, 16'h0);
    #2 chk("pre_burst_m0", m0_gnt, 1'b1);
    tick(); drv1(1, 1, 8'd4, 2'b11, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #2 chk("burst_m1", {m1_gnt, m0_gnt}, 2'b10);
      if (i < 3) tick();
    end
    tick(); drv1(0, 0, 8'd0, 2'b11, 16'h0);
    #2 chk("post_burst_m0", {m1_gnt, m0_gnt}, 2'b01);
    tick(); drv0(0, 0, 8'd0, 2'b11, 16'h0);

    // Out-of-range read.
    tick(); drv0(1, 0, 8'd200, 2'b11, 16'h0);
    #2 chk("oor_gnt", m0_gnt, 1'b1);
    chk("oor_cen", ram_cen, 1'b1);
    tick(); drv0(0, 0, 8'd0, 2'b11, 16'h0);
    #2 chk("oor_ack_err_dout", {m0_ack, m0_err, m0_dout}, {1'b1, 1'b1, 16'h0});

    // Upper-byte write merges into the existing word.
    tick(); drv0(1, 0, 8'd9, 2'b00, 16'h3456);
    tick(); drv0(1, 0, 8'd9, 2'b01, 16'h12FF);
    tick(); drv0(1, 0, 8'd9, 2'b11, 16'h0);
    tick(); drv0(0, 0, 8'd0, 2'b11, 16'h0);
    #2 chk("byte_merge", m0_dout, 16'h1256);

    // Reset arriving in a would-be grant cycle must not touch the RAM.
    tick(); drv0(1, 0, 8'd9, 2'b00, 16'hFFFF); rst_n = 1'b0;
    #2 chk("rst_gnt_blocked", {m0_gnt, ram_cen}, 2'b01);
    tick(); drv0(0, 0, 8'd0, 2'b11, 16'h0);
    tick(); rst_n = 1'b1;
    #2 chk("rst_no_ack", m0_ack, 1'b0);
    tick(); drv0(1, 0, 8'd9, 2'b11, 16'h0);
    tick(); drv0(0, 0, 8'd0, 2'b11, 16'h0);
    #2 chk("rst_mem_kept", m0_dout, 16'h1256);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 249) != 0);
      drv0($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 16'($urandom));
      drv1($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 16'($urandom));
    end
    tick(); rst_n = 1'b1;
    drv0(0, 0, 8'd0, 2'b11, 16'h0); drv1(0, 0, 8'd0, 2'b11, 16'h0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
